// File: rtl/axicb_scfifo_fwft.sv
// rtl/axicb_scfifo_fwft.sv - single-clock FWFT FIFO with fill count and almost-full/empty flags
// Optional sticky overflow/underflow flags under AXICB_SCFIFO_ERR_EN.
module axicb_scfifo_fwft #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  afull,
  output logic                  aempty,
  output logic [1:0]            err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_T  = CW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_T = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  rst_done;
  logic                  ram_empty;
  logic                  ram_full;
  logic                  wr_en;
  logic                  rd_en;
  logic                  out_fire;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  // rst_done keeps in_ready low while reset is held, without a path from in_valid
  assign in_ready  = rst_done && !ram_full;
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = !ram_empty && (!out_valid || out_ready);
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    count_next = count;
    if (wr_en && !out_fire)
      count_next = count + CW'(1);
    else if (!wr_en && out_fire)
      count_next = count - CW'(1);
  end

  always_ff @(posedge aclk) begin
    if (aresetn && !flush && wr_en)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rst_done  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      count     <= '0;
      afull     <= 1'b0;
      aempty    <= 1'b1;
    end else if (flush) begin
      rst_done  <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      afull     <= 1'b0;
      aempty    <= 1'b1;
    end else begin
      rst_done <= 1'b1;
      if (wr_en)
        wr_ptr <= wr_ptr + CW'(1);
      // the read register is the output stage: refill whenever it empties or drains
      if (rd_en) begin
        rd_ptr    <= rd_ptr + CW'(1);
        out_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      count  <= count_next;
      afull  <= (count_next >= AFULL_T);
      aempty <= (count_next <= AEMPTY_T);
    end
  end

`ifdef AXICB_SCFIFO_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q <= 2'b00;
    end else begin
      if (in_valid && !in_ready)
        err_q[1] <= 1'b1;
      if (out_ready && !out_valid)
        err_q[0] <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

endmodule

// File: tb/tb_axicb_scfifo_fwft.sv
// tb/tb_axicb_scfifo_fwft.sv - directed vector bench for axicb_scfifo_fwft
module tb_axicb_scfifo_fwft;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       afull;
  logic       aempty;
  logic [1:0] err;

`ifdef AXICB_SCFIFO_ERR_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [4:0] e_cnt;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int passes = 0;

  axicb_scfifo_fwft dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .afull     (afull),
    .aempty    (aempty),
    .err       (err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp)
      passes++;
    else
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, int'(in_ready), 0);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " out_data"}, int'(out_data), 0);
    chk({tag, " count"}, int'(count), 0);
    chk({tag, " afull"}, int'(afull), 0);
    chk({tag, " aempty"}, int'(aempty), 1);
    chk({tag, " err"}, int'(err), 0);
  endtask

  initial begin
    logic [7:0] q[$];
    int         cm;
    int         exp_w;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       wr;
    logic       fire;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 5'd1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};

    // reset state while aresetn held low
    step();
    step();
    chk_reset_vals("rst");
    aresetn = 1'b1;
    step();
    chk("rst release in_ready", int'(in_ready), 1);

    // vector table: FWFT latency, simultaneous in/out, drain, flush with write
    for (int i = 0; i < 8; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      step();
      chk($sformatf("vec%0d in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
      chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      if (vecs[i].e_ov)
        chk($sformatf("vec%0d out_data", i), int'(out_data), int'(vecs[i].e_od));
      chk($sformatf("vec%0d count", i), int'(count), int'(vecs[i].e_cnt));
      chk($sformatf("vec%0d afull", i), int'(afull), int'(vecs[i].e_af));
      chk($sformatf("vec%0d aempty", i), int'(aempty), int'(vecs[i].e_ae));
    end
    flush = 1'b0;

    // fill to 17, overflow attempt, drain in order
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      chk($sformatf("fill%0d count", i), int'(count), i + 1);
      chk($sformatf("fill%0d afull", i), int'(afull), (i + 1 >= 14) ? 1 : 0);
      chk($sformatf("fill%0d in_ready", i), int'(in_ready), (i < 16) ? 1 : 0);
    end
    in_data = 8'h99;
    step();
    in_valid = 1'b0;
    chk("overflow count", int'(count), 17);
    chk("overflow err", int'(err), ERR_ON ? 2 : 0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("drain%0d out_valid", i), int'(out_valid), 1);
      chk($sformatf("drain%0d out_data", i), int'(out_data), i);
      step();
    end
    chk("drain count", int'(count), 0);
    chk("drain out_valid", int'(out_valid), 0);
    out_ready = 1'b0;

    // streaming at full rate
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    exp_w = 0;
    for (int c = 0; c < 100; c++) begin
      in_data = 8'(c);
      if (out_valid) begin
        chk($sformatf("stream data%0d", exp_w), int'(out_data), exp_w);
        exp_w++;
      end
      step();
      chk($sformatf("stream count%0d", c), int'(count >= 5'd1 && count <= 5'd2), 1);
    end
    chk("stream words", exp_w, 98);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // flush with coincident write
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h20 + i);
      step();
    end
    chk("preflush count", int'(count), 8);
    flush   = 1'b1;
    in_data = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush count", int'(count), 0);
    chk("flush out_valid", int'(out_valid), 0);
    chk("flush aempty", int'(aempty), 1);
    chk("flush afull", int'(afull), 0);
    step();
    chk("postflush count", int'(count), 0);
    chk("postflush out_valid", int'(out_valid), 0);
    in_valid = 1'b1;
    in_data  = 8'h42;
    step();
    in_valid = 1'b0;
    step();
    chk("postflush word valid", int'(out_valid), 1);
    chk("postflush word data", int'(out_data), 8'h42);

    // underflow flag, then reset mid-traffic
    do_reset();
    out_ready = 1'b1;
    step();
    chk("underflow err", int'(err), ERR_ON ? 1 : 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h50 + i);
      step();
    end
    aresetn   = 1'b0;
    out_ready = 1'b0;
    step();
    chk_reset_vals("midrst");
    aresetn  = 1'b1;
    in_valid = 1'b0;
    step();
    chk("midrst release in_ready", int'(in_ready), 1);
    chk("midrst release count", int'(count), 0);
    chk("midrst release out_valid", int'(out_valid), 0);

    // random traffic against a scoreboard
    do_reset();
    cm = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      chk("rnd in_ready", int'(in_ready), (cm != 17) ? 1 : 0);
      if (prev_stall)
        chk("rnd stall stable", int'(out_data), int'(prev_data));
      wr   = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        if (q.size() == 0) begin
          chk("rnd pop empty", 1, 0);
        end else begin
          chk("rnd data", int'(out_data), int'(q[0]));
          void'(q.pop_front());
        end
      end
      if (wr)
        q.push_back(in_data);
      cm = cm + int'(wr) - int'(fire);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      step();
      chk("rnd count", int'(count), cm);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
